axi4_ocram_initiator: RTL and testbench

AXI4 master-side initiator: the block that drives the on-chip RAM's AXI4 slave port. It turns a simple command/stream interface into single-ID INCR bursts of 64-bit beats on AXI4, and returns read data and completion status. It is used by test harnesses and DMA-style agents to load and check the ocram through its AXI4 → APB → sramc path. It allows one outstanding transaction at a time.

---
 rtl/axi4_ocram_initiator_if.sv | 75 +++++++
 rtl/axi4_ocram_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_ocram_initiator.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_ocram_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ocram_initiator_if
// Description : AXI4 bus bundle between the ocram initiator (master) and the
//               ocram AXI4 slave port. Five channels, single ID.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_ocram_initiator_if #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // Write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    // Write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    // Write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    // Read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_ocram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ocram_initiator
// Description : Turns a command + write/read stream interface into single-ID
//               INCR bursts of 64-bit beats on AXI4. One transaction in
//               flight; reports completion and error status with done.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_ocram_initiator #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TXN_ID     = 0
) (
    input  wire                    clk,
    input  wire                    rst,
    // Command interface
    input  wire                    cmd_valid,
    output logic                   cmd_ready,
    input  wire                    cmd_write,
    input  wire [ADDR_WIDTH-1:0]   cmd_addr,
    input  wire [7:0]              cmd_len,
    // Write beat stream
    input  wire [DATA_WIDTH-1:0]   wr_data,
    input  wire [STRB_WIDTH-1:0]   wr_strb,
    input  wire                    wr_valid,
    output logic                   wr_ready,
    // Read beat stream
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_last,
    output logic                   rd_valid,
    input  wire                    rd_ready,
    // Completion
    output logic                   done,
    output logic                   done_err,
    // AXI4 master port
    axi4_ocram_initiator_if.master axi
);

    localparam logic [ID_WIDTH-1:0] c_txn_id    = ID_WIDTH'(TXN_ID);
    localparam logic [2:0]          c_size_8b   = 3'd3;
    localparam logic [1:0]          c_burst_inc = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_beat_err;
    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture, beat counter and sticky read error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= cmd_addr;
                r_len  <= cmd_len;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end else if (w_w_hs || w_r_hs) begin
                // Last beat lands on r_cnt == r_len (max 255), so no wrap mid-burst
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_r_hs && w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next state and all outputs; channel payloads are zero outside their state
    always_comb begin
        w_state_nxt = r_state;
        w_w_hs      = 1'b0;
        w_r_hs      = 1'b0;
        w_beat_err  = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_data     = '0;
        rd_last     = 1'b0;
        rd_valid    = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awsize  = '0;
        axi.awburst = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                axi.awid    = c_txn_id;
                axi.awaddr  = r_addr;
                axi.awlen   = r_len;
                axi.awsize  = c_size_8b;
                axi.awburst = c_burst_inc;
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    w_state_nxt = S_W;
                end
            end
            S_W: begin
                axi.wvalid = wr_valid;
                axi.wdata  = wr_data;
                axi.wstrb  = wr_strb;
                axi.wlast  = (r_cnt == r_len);
                wr_ready   = axi.wready;
                w_w_hs     = wr_valid && axi.wready;
                if (w_w_hs && (r_cnt == r_len)) begin
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    done        = 1'b1;
                    done_err    = r_err || (axi.bresp != 2'b00) || (axi.bid != c_txn_id);
                    w_state_nxt = S_IDLE;
                end
            end
            S_AR: begin
                axi.arid    = c_txn_id;
                axi.araddr  = r_addr;
                axi.arlen   = r_len;
                axi.arsize  = c_size_8b;
                axi.arburst = c_burst_inc;
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                rd_valid   = axi.rvalid;
                rd_data    = axi.rdata;
                rd_last    = axi.rlast;
                axi.rready = rd_ready;
                w_r_hs     = axi.rvalid && rd_ready;
                w_beat_err = (axi.rresp != 2'b00) || (axi.rid != c_txn_id);
                if (w_r_hs && axi.rlast) begin
                    done        = 1'b1;
                    // Early or late rlast relative to the requested length is an error
                    done_err    = r_err || w_beat_err || (r_cnt != r_len);
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_ocram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_ocram_initiator
// Description : Self-checking bench for axi4_ocram_initiator with a memory
//               backed AXI4 slave and a per-cycle transaction-phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_ocram_initiator;

    localparam int TXN_ID = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [63:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done, done_err;

    always #5 clk = ~clk;

    axi4_ocram_initiator_if #(.ID_WIDTH(8), .DATA_WIDTH(64), .ADDR_WIDTH(32), .STRB_WIDTH(8)) axi ();

    axi4_ocram_initiator #(
        .ID_WIDTH(8), .DATA_WIDTH(64), .ADDR_WIDTH(32), .STRB_WIDTH(8), .TXN_ID(TXN_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_err(done_err),
        .axi(axi)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write source data and expected read data (filled independently)
    logic [63:0] wbuf [256];
    logic [63:0] rbuf [256];

    // Slave knobs
    bit          k_wtoggle   = 1'b0;
    logic [1:0]  k_bresp     = 2'b00;
    logic [7:0]  k_bid       = 8'd0;
    int          k_rerr_beat = -1;

    // ------------------------------------------------------------------
    // Memory-backed AXI4 slave: drives at negedge, samples handshakes at +3
    // ------------------------------------------------------------------
    logic [63:0] mem [logic [31:0]];
    logic [31:0] s_waddr, s_raddr, s_a;
    logic [63:0] s_word;
    int          s_wcnt, s_rlen, s_ridx, s_whs;
    bit          s_bpend, s_ract, s_tog;

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = '0;
        s_bpend = 0; s_ract = 0; s_wcnt = 0; s_whs = 0; s_tog = 0;
        s_waddr = '0; s_raddr = '0; s_rlen = 0; s_ridx = 0;
        forever begin
            @(negedge clk);
            s_tog       = ~s_tog;
            axi.awready = 1'b1;
            axi.arready = 1'b1;
            axi.wready  = k_wtoggle ? s_tog : 1'b1;
            axi.bvalid  = s_bpend;
            axi.bresp   = s_bpend ? k_bresp : 2'b00;
            axi.bid     = s_bpend ? 8'(TXN_ID) + k_bid : 8'd0;
            axi.rvalid  = s_ract;
            axi.rid     = 8'(TXN_ID);
            if (s_ract) begin
                s_a        = s_raddr + 32'(8 * s_ridx);
                axi.rdata  = mem.exists(s_a) ? mem[s_a] : 64'd0;
                axi.rlast  = (s_ridx == s_rlen);
                axi.rresp  = (s_ridx == k_rerr_beat) ? 2'b10 : 2'b00;
            end else begin
                axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
            end
            #3;
            if (rst) begin
                s_bpend = 0; s_ract = 0; s_wcnt = 0;
            end else begin
                if (axi.awvalid && axi.awready) begin
                    s_waddr = axi.awaddr; s_wcnt = 0;
                end
                if (axi.wvalid && axi.wready) begin
                    s_a    = s_waddr + 32'(8 * s_wcnt);
                    s_word = mem.exists(s_a) ? mem[s_a] : 64'd0;
                    for (int b = 0; b < 8; b++)
                        if (axi.wstrb[b]) s_word[8*b +: 8] = axi.wdata[8*b +: 8];
                    mem[s_a] = s_word;
                    s_wcnt++; s_whs++;
                    if (axi.wlast) s_bpend = 1;
                end
                if (axi.bvalid && axi.bready) s_bpend = 0;
                if (axi.arvalid && axi.arready) begin
                    s_raddr = axi.araddr; s_rlen = int'(axi.arlen); s_ridx = 0; s_ract = 1;
                end
                if (axi.rvalid && axi.rready) begin
                    if (axi.rlast) s_ract = 0;
                    s_ridx++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Done monitor
    // ------------------------------------------------------------------
    int   done_cnt = 0;
    logic last_err = 1'b0;
    always @(negedge clk) begin
        #3;
        if (!rst && done === 1'b1) begin
            done_cnt++;
            last_err = done_err;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle model: transaction phase derived from observed handshakes
    // ------------------------------------------------------------------
    typedef enum int {P_IDLE, P_ADDR, P_DATA, P_RESP} phase_t;
    phase_t      m_phase = P_IDLE;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    int          m_beats;
    bit          m_err;
    logic        e_wv, e_rv, e_done, e_err, e_berr;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            m_phase = P_IDLE;
        end else begin
            chk("cmd_ready", cmd_ready, m_phase == P_IDLE);
            chk("awvalid", axi.awvalid, m_phase == P_ADDR && m_wr);
            if (m_phase == P_ADDR && m_wr) begin
                chk("awaddr", axi.awaddr, m_addr);
                chk("awlen", axi.awlen, m_len);
                chk("awsize", axi.awsize, 3);
                chk("awburst", axi.awburst, 1);
                chk("awid", axi.awid, TXN_ID);
            end
            chk("arvalid", axi.arvalid, m_phase == P_ADDR && !m_wr);
            if (m_phase == P_ADDR && !m_wr) begin
                chk("araddr", axi.araddr, m_addr);
                chk("arlen", axi.arlen, m_len);
                chk("arsize", axi.arsize, 3);
                chk("arburst", axi.arburst, 1);
                chk("arid", axi.arid, TXN_ID);
            end
            e_wv = (m_phase == P_DATA && m_wr) ? wr_valid : 1'b0;
            chk("wvalid", axi.wvalid, e_wv);
            chk("wr_ready", wr_ready, (m_phase == P_DATA && m_wr) ? axi.wready : 1'b0);
            if (e_wv) begin
                chk("wdata", axi.wdata, wr_data);
                chk("wstrb", axi.wstrb, wr_strb);
                chk("wlast", axi.wlast, m_beats == int'(m_len));
            end
            chk("bready", axi.bready, m_phase == P_RESP);
            e_rv = (m_phase == P_DATA && !m_wr) ? axi.rvalid : 1'b0;
            chk("rd_valid", rd_valid, e_rv);
            chk("rready", axi.rready, (m_phase == P_DATA && !m_wr) ? rd_ready : 1'b0);
            if (e_rv) begin
                chk("rd_data", rd_data, axi.rdata);
                chk("rd_last", rd_last, axi.rlast);
            end
            e_done = 1'b0;
            e_err  = 1'b0;
            e_berr = (axi.rresp != 2'b00) || (axi.rid != 8'(TXN_ID));
            if (m_phase == P_RESP && axi.bvalid) begin
                e_done = 1'b1;
                e_err  = (axi.bresp != 2'b00) || (axi.bid != 8'(TXN_ID));
            end
            if (m_phase == P_DATA && !m_wr && axi.rvalid && rd_ready && axi.rlast) begin
                e_done = 1'b1;
                e_err  = m_err || e_berr || (m_beats != int'(m_len));
            end
            chk("done", done, e_done);
            if (e_done) chk("done_err", done_err, e_err);

            case (m_phase)
                P_IDLE: if (cmd_valid) begin
                    m_wr = cmd_write; m_addr = cmd_addr; m_len = cmd_len;
                    m_beats = 0; m_err = 0; m_phase = P_ADDR;
                end
                P_ADDR: if (m_wr ? axi.awready : axi.arready) m_phase = P_DATA;
                P_DATA: begin
                    if (m_wr && wr_valid && axi.wready) begin
                        if (m_beats == int'(m_len)) m_phase = P_RESP;
                        m_beats++;
                    end
                    if (!m_wr && axi.rvalid && rd_ready) begin
                        if (e_berr) m_err = 1;
                        if (axi.rlast) m_phase = P_IDLE;
                        m_beats++;
                    end
                end
                P_RESP: if (axi.bvalid) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks: called and returning at a negedge
    // ------------------------------------------------------------------
    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        #3;
        while (!cmd_ready && t < 100) begin
            @(negedge clk); #3; t++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [7:0] len);
        int k = 0;
        int t = 0;
        while (k <= int'(len) && t < 2000) begin
            wr_valid = 1'b1; wr_data = wbuf[k]; wr_strb = 8'hFF;
            #3;
            if (wr_valid && wr_ready) k++;
            @(negedge clk); t++;
        end
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
        chk("wr_beats", k, int'(len) + 1);
    endtask

    task automatic read_beats(input logic [7:0] len, input int stall_at, input int stall_n);
        int k = 0;
        int s = 0;
        int t = 0;
        while (k <= int'(len) && t < 2000) begin
            rd_ready = !(k == stall_at && s < stall_n);
            if (!rd_ready) s++;
            #3;
            if (rd_valid && rd_ready) begin
                chk("rd_word", rd_data, rbuf[k]);
                chk("rd_last_pos", rd_last, k == int'(len));
                k++;
            end
            @(negedge clk); t++;
        end
        rd_ready = 1'b0;
        chk("rd_beats", k, int'(len) + 1);
    endtask

    task automatic wait_done(input int start, input logic exp_err);
        int t = 0;
        while (done_cnt == start && t < 100) begin
            @(negedge clk); t++;
        end
        chk("done_count", done_cnt, start + 1);
        chk("done_err_txn", last_err, exp_err);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic exp_err);
        int d0 = done_cnt;
        send_cmd(1'b1, a, l);
        write_beats(l);
        wait_done(d0, exp_err);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int stall_at,
                           input int stall_n, input logic exp_err);
        int d0 = done_cnt;
        send_cmd(1'b0, a, l);
        read_beats(l, stall_at, stall_n);
        wait_done(d0, exp_err);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_awvalid"}, axi.awvalid, 1'b0);
        chk({tag, "_wvalid"}, axi.wvalid, 1'b0);
        chk({tag, "_arvalid"}, axi.arvalid, 1'b0);
        chk({tag, "_rready"}, axi.rready, 1'b0);
        chk({tag, "_bready"}, axi.bready, 1'b0);
        chk({tag, "_wr_ready"}, wr_ready, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int k, t, d0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3; check_idle_outputs("reset");
        @(negedge clk);

        // Single-beat write and readback
        wbuf[0] = 64'h1122334455667788;
        do_write(32'h100, 8'd0, 1'b0);
        rbuf[0] = 64'h1122334455667788;
        do_read(32'h100, 8'd0, -1, 0, 1'b0);

        // 4-beat write with wready low every other cycle
        wbuf[0] = 64'hA0A0_0000_0000_0001; wbuf[1] = 64'hA0A0_0000_0000_0002;
        wbuf[2] = 64'hA0A0_0000_0000_0003; wbuf[3] = 64'hA0A0_0000_0000_0004;
        k_wtoggle = 1'b1;
        k = s_whs;
        do_write(32'h200, 8'd3, 1'b0);
        chk("w_handshakes", s_whs - k, 4);
        k_wtoggle = 1'b0;
        rbuf[0] = 64'hA0A0_0000_0000_0001; rbuf[1] = 64'hA0A0_0000_0000_0002;
        rbuf[2] = 64'hA0A0_0000_0000_0003; rbuf[3] = 64'hA0A0_0000_0000_0004;
        do_read(32'h200, 8'd3, -1, 0, 1'b0);

        // 8-beat read with a 3-cycle consumer stall at beat 5
        for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        do_write(32'h400, 8'd7, 1'b0);
        for (int i = 0; i < 8; i++) rbuf[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        do_read(32'h400, 8'd7, 4, 3, 1'b0);

        // Error responses
        k_bresp = 2'b10;
        wbuf[0] = 64'hDEAD_BEEF_0000_0000;
        do_write(32'h500, 8'd0, 1'b1);
        k_bresp = 2'b00;
        k_rerr_beat = 1;
        do_read(32'h400, 8'd3, -1, 0, 1'b1);
        k_rerr_beat = -1;
        k_bid = 8'd1;
        do_write(32'h508, 8'd0, 1'b1);
        k_bid = 8'd0;

        // Command held high during a busy burst
        wbuf[0] = 64'h3333_0000_0000_0001; wbuf[1] = 64'h3333_0000_0000_0002;
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 8'd1;
        #3; chk("busy_first_accept", cmd_ready, 1'b1);
        @(negedge clk);
        k = 0; t = 0;
        while (done_cnt == d0 && t < 50) begin
            wr_valid = (k <= 1); wr_data = wbuf[k & 1]; wr_strb = 8'hFF;
            #3; chk("busy_cmd_ready", cmd_ready, 1'b0);
            if (wr_valid && wr_ready) k++;
            @(negedge clk); t++;
        end
        wr_valid = 1'b0;
        chk("busy_done", done_cnt, d0 + 1);
        #3; chk("cmd_ready_after_done", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #3; chk("cmd_to_awvalid", axi.awvalid, 1'b1);
        @(negedge clk);
        write_beats(8'd1);
        wait_done(d0 + 1, 1'b0);

        // Reset during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h5555_0000_0000_0000 | 64'(i);
        d0 = done_cnt;
        send_cmd(1'b1, 32'h600, 8'd7);
        k = 0; t = 0;
        while (k < 2 && t < 50) begin
            wr_valid = 1'b1; wr_data = wbuf[k]; wr_strb = 8'hFF;
            #3; if (wr_valid && wr_ready) k++;
            @(negedge clk); t++;
        end
        wr_valid = 1'b1; wr_data = wbuf[2]; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        #3; check_idle_outputs("mid_reset");
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", done_cnt, d0);

        // Full 256-beat burst
        for (int i = 0; i < 256; i++) wbuf[i] = {32'hA5A5_0000 + 32'(i), ~32'(i)};
        do_write(32'h1000, 8'd255, 1'b0);
        for (int i = 0; i < 256; i++) rbuf[i] = {32'hA5A5_0000 + 32'(i), ~32'(i)};
        do_read(32'h1000, 8'd255, -1, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
